// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction memory between the fetch port and the loader port.
// Define IMEM_ARB_STARVE_EN to force a loader grant after STARVE_LIMIT denied cycles.
module imem_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             f_req_i,
    input  logic [DEPTH-1:0] f_addr_i,
    output logic             f_gnt_o,
    output logic             f_rvalid_o,
    output logic [WIDTH-1:0] f_rdata_o,
    input  logic             l_req_i,
    input  logic             l_we_i,
    input  logic             l_lock_i,
    input  logic [DEPTH-1:0] l_addr_i,
    input  logic [WIDTH-1:0] l_wdata_i,
    output logic             l_gnt_o,
    output logic             l_rvalid_o,
    output logic [WIDTH-1:0] l_rdata_o,
    output logic             locked_o,
    output logic             m_wr_o,
    output logic             m_rd_o,
    output logic [DEPTH-1:0] m_addr_o,
    output logic [WIDTH-1:0] m_data_in_o,
    input  logic [WIDTH-1:0] m_data_out_i
);

    typedef enum logic {StRun, StLocked} state_e;

    state_e state_q, state_d;
    logic   f_rv_q, l_rv_q;
    logic   starve_hit;

    if (STARVE_LIMIT < 1) begin : g_param_check
        $error("STARVE_LIMIT must be at least 1");
    end

`ifdef IMEM_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign starve_hit = (cnt_q == CntW'(STARVE_LIMIT)) & l_req_i;

    // Only denied loader cycles in RUN advance the count; it saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StLocked || l_gnt_o) begin
            cnt_d = '0;
        end else if (l_req_i && cnt_q != CntW'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (l_req_i && l_lock_i && l_gnt_o) state_d = StLocked;
            StLocked: if (!l_lock_i) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // Grants are masked while reset is asserted so every output reads 0 in reset.
    always_comb begin
        f_gnt_o = 1'b0;
        l_gnt_o = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                StRun: begin
                    f_gnt_o = f_req_i & ~starve_hit;
                    l_gnt_o = l_req_i & (~f_req_i | starve_hit);
                end
                StLocked: l_gnt_o = l_req_i;
                default: ;
            endcase
        end
    end

    assign locked_o = (state_q == StLocked);

    always_comb begin
        m_wr_o      = 1'b0;
        m_rd_o      = 1'b0;
        m_addr_o    = '0;
        m_data_in_o = '0;
        if (f_gnt_o) begin
            m_rd_o   = 1'b1;
            m_addr_o = f_addr_i;
        end else if (l_gnt_o) begin
            m_wr_o      = l_we_i;
            m_rd_o      = ~l_we_i;
            m_addr_o    = l_addr_i;
            m_data_in_o = l_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_rv_q <= 1'b0;
            l_rv_q <= 1'b0;
        end else begin
            f_rv_q <= f_gnt_o;
            l_rv_q <= l_gnt_o & ~l_we_i;
        end
    end

    assign f_rvalid_o = f_rv_q;
    assign l_rvalid_o = l_rv_q;
    assign f_rdata_o  = f_rv_q ? m_data_out_i : '0;
    assign l_rdata_o  = l_rv_q ? m_data_out_i : '0;

endmodule
